// File: rtl/sram_rmw_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sram_rmw_ctrl                                                   |
// | Purpose  : Clocked sequencer for an asynchronous single-port pixel SRAM.   |
// |            Turns READ / WRITE / INC / CLR requests into SRAM read/write    |
// |            strobes that honour minimum pulse width, precharge and          |
// |            address/data stability. INC is a read-modify-write +1 used for  |
// |            per-pixel hit counters.                                         |
// | Config   : define SRAM_SAT_EN to make INC saturate at all-ones instead of  |
// |            wrapping to zero (ovf is flagged in both cases).                |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module sram_rmw_ctrl #(
  parameter int ADDR_BITS    = 6,
  parameter int DATA_BITS    = 12,
  parameter int READ_CYCLES  = 2,
  parameter int WRITE_CYCLES = 2,
  parameter int PRE_CYCLES   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [DATA_BITS-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [DATA_BITS-1:0] rsp_data,
  output logic                 ovf,
  output logic                 sram_read,
  output logic                 sram_write,
  output logic [ADDR_BITS-1:0] sram_addr,
  output logic [DATA_BITS-1:0] sram_din,
  input  logic [DATA_BITS-1:0] sram_dout,
  input  logic                 sram_read_done,
  input  logic                 sram_write_done
);

  // Request opcodes
  localparam logic [1:0] c_OP_READ  = 2'b00;
  localparam logic [1:0] c_OP_WRITE = 2'b01;
  localparam logic [1:0] c_OP_INC   = 2'b10;
  localparam logic [1:0] c_OP_CLR   = 2'b11;

  // The GAP state needs one extra cycle to register the incremented value
  // before the PRE_CYCLES of din setup begin, hence PRE_CYCLES+1 there.
  localparam int c_GAP_CYCLES = PRE_CYCLES + 1;
  localparam int c_MAX_RW     = (READ_CYCLES > WRITE_CYCLES) ? READ_CYCLES : WRITE_CYCLES;
  localparam int c_CNT_MAX    = (c_MAX_RW > c_GAP_CYCLES) ? c_MAX_RW : c_GAP_CYCLES;
  localparam int c_CNT_BITS   = (c_CNT_MAX < 2) ? 1 : $clog2(c_CNT_MAX + 1);

  localparam logic [c_CNT_BITS-1:0] c_CNT_ONE = c_CNT_BITS'(1);
  localparam logic [c_CNT_BITS-1:0] c_RD_CNT  = c_CNT_BITS'(READ_CYCLES);
  localparam logic [c_CNT_BITS-1:0] c_WR_CNT  = c_CNT_BITS'(WRITE_CYCLES);
  localparam logic [c_CNT_BITS-1:0] c_PRE_CNT = c_CNT_BITS'(PRE_CYCLES);
  localparam logic [c_CNT_BITS-1:0] c_GAP_CNT = c_CNT_BITS'(c_GAP_CYCLES);
  localparam logic [DATA_BITS-1:0]  c_D_ONE   = DATA_BITS'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_READ      = 3'd1,
    S_GAP       = 3'd2,
    S_WRITE     = 3'd3,
    S_PRECHARGE = 3'd4
  } state_t;

  state_t                r_state;
  logic [c_CNT_BITS-1:0] r_cnt;      // elapsed strobe cycles, or remaining low cycles
  logic [1:0]            r_op;       // operation in flight
  logic [DATA_BITS-1:0]  r_rdata;    // word captured at the end of the read strobe
  logic                  r_rsp_pend; // READ response due on first precharge cycle

  logic                  w_all_ones;
  logic [DATA_BITS-1:0]  w_sum;

  assign w_all_ones = &r_rdata;

`ifdef SRAM_SAT_EN
  // Counter sticks at full scale once it gets there
  assign w_sum = w_all_ones ? r_rdata : (r_rdata + c_D_ONE);
`else
  // Counter wraps to zero; ovf tells the readout it happened
  assign w_sum = r_rdata + c_D_ONE;
`endif

  // Sequencer: every output is a flop so SRAM strobes never glitch on inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_PRECHARGE;
      r_cnt      <= c_PRE_CNT;
      r_op       <= c_OP_READ;
      r_rdata    <= '0;
      r_rsp_pend <= 1'b0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      ovf        <= 1'b0;
      sram_read  <= 1'b0;
      sram_write <= 1'b0;
      sram_addr  <= '0;
      sram_din   <= '0;
    end else begin
      // Response flags are single-cycle pulses
      rsp_valid <= 1'b0;
      ovf       <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            sram_addr <= req_addr;
            r_op      <= req_op;
            r_cnt     <= c_CNT_ONE;
            case (req_op)
              c_OP_WRITE: begin
                sram_din   <= req_wdata;
                sram_write <= 1'b1;
                r_state    <= S_WRITE;
              end
              c_OP_CLR: begin
                sram_din   <= '0;
                sram_write <= 1'b1;
                r_state    <= S_WRITE;
              end
              default: begin
                // READ and INC both start with a read strobe
                sram_read <= 1'b1;
                r_state   <= S_READ;
              end
            endcase
          end
        end

        S_READ: begin
          if ((r_cnt >= c_RD_CNT) && sram_read_done) begin
            sram_read <= 1'b0;
            r_rdata   <= sram_dout;
            if (r_op == c_OP_INC) begin
              r_state <= S_GAP;
              r_cnt   <= c_GAP_CNT;
            end else begin
              r_state    <= S_PRECHARGE;
              r_cnt      <= c_PRE_CNT;
              r_rsp_pend <= 1'b1;
            end
          end else if (r_cnt < c_RD_CNT) begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end

        S_GAP: begin
          // First GAP cycle loads the new count, the rest give din setup time
          if (r_cnt == c_GAP_CNT) begin
            sram_din <= w_sum;
          end
          if (r_cnt <= c_CNT_ONE) begin
            sram_write <= 1'b1;
            r_cnt      <= c_CNT_ONE;
            r_state    <= S_WRITE;
          end else begin
            r_cnt <= r_cnt - c_CNT_ONE;
          end
        end

        S_WRITE: begin
          if ((r_cnt >= c_WR_CNT) && sram_write_done) begin
            sram_write <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_data   <= sram_din;
            ovf        <= (r_op == c_OP_INC) && w_all_ones;
            r_state    <= S_PRECHARGE;
            r_cnt      <= c_PRE_CNT;
          end else if (r_cnt < c_WR_CNT) begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end

        S_PRECHARGE: begin
          if (r_rsp_pend) begin
            rsp_valid  <= 1'b1;
            rsp_data   <= r_rdata;
            r_rsp_pend <= 1'b0;
          end
          if (r_cnt <= c_CNT_ONE) begin
            req_ready <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - c_CNT_ONE;
          end
        end

        default: begin
          sram_read  <= 1'b0;
          sram_write <= 1'b0;
          req_ready  <= 1'b0;
          r_cnt      <= c_PRE_CNT;
          r_state    <= S_PRECHARGE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
